// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over 32 iterations, with single-cycle fast paths for divide corner cases.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is taken on a rising edge only in IDLE or DONE with flush low;
  // done is a one-cycle pulse and result/rd_out stay valid until the next done.
  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] b_mag_q;
  logic [2*XLEN-1:0] acc_q;
  logic [5:0]      cnt_q;
  logic            neg_q_q, neg_r_q, fast_q;
  logic [4:0]      rd_pend_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic            accept, finish, iterate;
  logic            is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf, fast;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] step, prod;
  logic [XLEN-1:0] quo, rem, final_val;

  assign accept  = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
  assign finish  = (state_q == S_BUSY) && !flush && (fast_q || cnt_q == 6'(XLEN));
  assign iterate = (state_q == S_BUSY) && !flush && !fast_q && (cnt_q != 6'(XLEN));

  always_comb begin
    is_div   = funct3[2];
    sgn_a    = is_div ? !funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    sgn_b    = is_div ? !funct3[0] : (funct3 == 3'b001);
    neg_a    = sgn_a && opA[XLEN-1];
    neg_b    = sgn_b && opB[XLEN-1];
    a_abs    = neg_a ? -opA : opA;
    b_abs    = neg_b ? -opB : opB;
    div_zero = is_div && (opB == '0);
    div_ovf  = is_div && !funct3[0] && (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
    fast     = div_zero || div_ovf;
  end

  // acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, b_mag_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = neg_q_q ? -acc_q : acc_q;
    quo  = neg_q_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (fast_q)       final_val = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    else if (op_q[2]) final_val = op_q[1] ? rem : quo;
    else              final_val = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_BUSY;
      S_BUSY:  if (flush) state_d = S_IDLE;
               else if (finish) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_BUSY : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Fast-path ops park their final answer in acc during one hidden BUSY cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q      <= '0;
      b_mag_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      fast_q    <= 1'b0;
      rd_pend_q <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      if (accept) begin
        op_q      <= funct3;
        b_mag_q   <= b_abs;
        acc_q     <= div_zero ? {opA, {XLEN{1'b1}}} :
                     div_ovf  ? {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}} :
                                {{XLEN{1'b0}}, a_abs};
        cnt_q     <= '0;
        neg_q_q   <= neg_a ^ neg_b;
        neg_r_q   <= neg_a;
        fast_q    <= fast;
        rd_pend_q <= rd_in;
      end else if (iterate) begin
        acc_q <= step;
        cnt_q <= cnt_q + 6'd1;
      end
      if (finish) begin
        result_q <= final_val;
        rd_out_q <= rd_pend_q;
      end
    end
  end

  assign busy      = (state_q == S_BUSY) && !fast_q;
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign rd_out    = rd_out_q;
  assign state_dbg = state_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the core. It takes the two source operands read from the register file (rs1/rs2 values), computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over several cycles, and presents a 32-bit result plus destination index to the writeback path that drives the register file's write data and write enable. Control stalls the pipeline while `busy` is high.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `CLK`  input  1  rising-edge clock.
- `RST_N`  input  1  asynchronous active-low reset.
- `start`  input  1  request; sampled on rising edges when the unit can accept.
- `funct3`  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `opA`  input  32  rs1 value (multiplicand/dividend).
- `opB`  input  32  rs2 value (multiplier/divisor).
- `rd_in`  input  5  destination register index, carried with the op.
- `flush`  input  1  synchronous abort of any in-flight op.
- `busy`  output  1  op in progress; new `start` ignored.
- `done`  output  1  one-cycle pulse; `result`/`rd_out` valid.
- `result`  output  32  final value; held until next accepted start.
- `rd_out`  output  5  captured `rd_in`; held with `result`.

## Operation
- States: IDLE, BUSY, DONE. Reset (RST_N low, any time, including mid-op) forces IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, iteration counter=0.
- Accept: `start`=1 in IDLE or DONE (and `flush`=0) latches `funct3`, `opA`, `opB`, `rd_in`; operands are not re-read afterwards.
- Signed handling: signed operands (MULH both, MULHSU opA only, DIV/REM both) are converted to magnitudes; core is unsigned; the sign is applied in the final iteration. Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Multiply: radix-2 shift-add over 32 iterations, 64-bit product. MUL returns bits [31:0], MULH/MULHSU/MULHU bits [63:32] of the correctly signed 64-bit product.
- Divide: restoring division, 32 iterations, 32-bit quotient and remainder. DIV/DIVU return quotient, REM/REMU remainder.
- Fast paths (skip iterations, go straight to DONE):
  - divisor 0: quotient 0xFFFFFFFF (DIV and DIVU), remainder = opA.
  - DIV/REM with opA=0x80000000, opB=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- BUSY -> DONE when the counter reaches 32. DONE -> IDLE next cycle unless `start` is accepted, in which case DONE -> BUSY (or DONE again for a fast path).
- `start` while BUSY: ignored, no state change.
- `flush`=1: BUSY/DONE -> IDLE, `done` forced 0, `result`/`rd_out` keep last values; a simultaneous `start` is ignored.
- All arithmetic is modulo 2^32 (2^64 for product); no exceptions are raised.

## Timing
- Edge E0 samples `start`. Normal ops: `busy`=1 from E0 through E32; `done`=1 after E33 for exactly one cycle, with `busy`=0 in that cycle.
- Fast paths: `busy` never asserts; `done`=1 after E1 for one cycle.
- `result`/`rd_out` update on the same edge that raises `done` and stay stable until the edge that raises the next `done`.
- Back-to-back: a `start` in the DONE cycle gives the next `done` 33 cycles later (fast path: 1 cycle); no idle bubble is required.
- Throughput: one normal op per 33 cycles.

## Test plan
- MUL opA=7, opB=0xFFFFFFFD (-3) -> `done` pulse 33 cycles after start, `result`=0xFFFFFFEB, `rd_out`=`rd_in`; MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each `done` at +33.
- DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of same -> 0; each `done` one cycle after start, `busy` never high.
- A `start` with different operands at cycle 10 of a DIV is ignored and the first result is unchanged. A `start` in the DONE cycle is accepted, and its `done` arrives 33 cycles later.
- `flush` at cycle 15 of a MUL -> no `done`, IDLE next cycle, `result` keeps its prior value. RST_N low at cycle 20 (asynchronous, mid-clock) -> all outputs 0 immediately. A new op after release completes normally.
